// File: rtl/rng_pkg.sv
// Shared types and helpers for the ranged LFSR random source.
// Holds the draw FSM encoding, maximal-length tap masks and the range mask function.
package rng_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_IDLE   = 2'd1,
      ST_DRAW   = 2'd2
   } rng_state_e;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hD008;
   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   // Smallest 2^k-1 covering r-1; r=0 selects the full range.
   function automatic logic [31:0] range_mask(input logic [31:0] r);
      logic [31:0] m;
      if (r == 32'd0) begin
         m = 32'hFFFF_FFFF;
      end else begin
         m = r - 32'd1;
         m = m | (m >> 1);
         m = m | (m >> 2);
         m = m | (m >> 4);
         m = m | (m >> 8);
         m = m | (m >> 16);
      end
      return m;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// XNOR Fibonacci LFSR with reseed; a seed that would land in the
// all-ones lock-up state is replaced by INITIAL_SEED.
module lfsr_core #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = 16'hD008,
   parameter logic [WIDTH-1:0] INITIAL_SEED = 16'h1314
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_seed,
   output logic [WIDTH-1:0] o_state
);

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] seeded_s;
   logic             fb_s;

   // Next state: keyed reseed with lock-up substitution, else one XNOR step
   always_comb begin
      seeded_s = i_seed ^ INITIAL_SEED;
      fb_s     = ~^(state_r & TAPS);
      if (i_load) begin
         if (&seeded_s) begin
            next_s = INITIAL_SEED;
         end else begin
            next_s = seeded_s;
         end
      end else begin
         next_s = {state_r[WIDTH-2:0], fb_s};
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= INITIAL_SEED;
      end else begin
         state_r <= next_s;
      end
   end

   assign o_state = state_r;

endmodule

// File: rtl/lfsr_ranged_rng.sv
// Free-running LFSR with warm-up and a request/valid port returning a
// uniform value in [0, R) by bounded rejection sampling.
module lfsr_ranged_rng
   import rng_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
   parameter logic [WIDTH-1:0] INITIAL_SEED = 16'h1314,
   parameter int               WARMUP       = 16,
   parameter int               MAX_TRIES    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_seed_load,
   input  logic [WIDTH-1:0] i_seed,
   input  logic             i_req,
   input  logic [WIDTH-1:0] i_range,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_value,
   output logic [WIDTH-1:0] o_raw
);

   localparam int               CNT_W       = $clog2(WARMUP + 1);
   localparam int               TRY_W       = $clog2(MAX_TRIES + 1);
   localparam logic [CNT_W-1:0] WARMUP_LOAD = CNT_W'(WARMUP);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
   localparam logic [TRY_W-1:0] TRY_LAST    = TRY_W'(MAX_TRIES - 1);
   localparam logic [TRY_W-1:0] TRY_ONE     = TRY_W'(1'b1);

   rng_state_e       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [TRY_W-1:0] tries_r, tries_s;
   logic [WIDTH-1:0] range_r, range_s;
   logic [WIDTH-1:0] mask_r, mask_s;
   logic [WIDTH-1:0] value_r, value_s;
   logic             valid_r, valid_s;
   logic             ready_r, ready_s;
   logic [WIDTH-1:0] raw_s;
   logic [WIDTH-1:0] cand_s;

   lfsr_core #(
      .WIDTH        (WIDTH),
      .TAPS         (TAPS),
      .INITIAL_SEED (INITIAL_SEED)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (i_seed_load),
      .i_seed  (i_seed),
      .o_state (raw_s)
   );

   // Next-state and output decode; a reseed overrides everything and drops any draw
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      tries_s = tries_r;
      range_s = range_r;
      mask_s  = mask_r;
      value_s = value_r;
      valid_s = 1'b0;
      ready_s = 1'b0;
      cand_s  = raw_s & mask_r;
      if (i_seed_load) begin
         state_s = ST_WARMUP;
         cnt_s   = WARMUP_LOAD;
      end else begin
         case (state_r)
            ST_WARMUP: begin
               cnt_s = cnt_r - CNT_ONE;
               if (cnt_r <= CNT_ONE) begin
                  state_s = ST_IDLE;
                  ready_s = 1'b1;
               end else begin
                  ready_s = 1'b0;
               end
            end
            ST_IDLE: begin
               if (i_req) begin
                  range_s = i_range;
                  mask_s  = WIDTH'(range_mask(32'(i_range)));
                  tries_s = {TRY_W{1'b0}};
                  state_s = ST_DRAW;
               end else begin
                  ready_s = 1'b1;
               end
            end
            ST_DRAW: begin
               // mask bounds cand below 2R, so the fallback subtract stays in range
               if ((range_r == {WIDTH{1'b0}}) || (cand_s < range_r)) begin
                  value_s = cand_s;
                  valid_s = 1'b1;
                  ready_s = 1'b1;
                  state_s = ST_IDLE;
               end else if (tries_r == TRY_LAST) begin
                  value_s = cand_s - range_r;
                  valid_s = 1'b1;
                  ready_s = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  tries_s = tries_r + TRY_ONE;
               end
            end
            default: begin
               state_s = ST_WARMUP;
               cnt_s   = WARMUP_LOAD;
            end
         endcase
      end
   end

   // FSM, warm-up counter, draw datapath and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_WARMUP;
         cnt_r   <= WARMUP_LOAD;
         tries_r <= {TRY_W{1'b0}};
         range_r <= {WIDTH{1'b0}};
         mask_r  <= {WIDTH{1'b0}};
         value_r <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         tries_r <= tries_s;
         range_r <= range_s;
         mask_r  <= mask_s;
         value_r <= value_s;
         valid_r <= valid_s;
         ready_r <= ready_s;
      end
   end

   assign o_ready = ready_r;
   assign o_valid = valid_r;
   assign o_value = value_r;
   assign o_raw   = raw_s;

endmodule

// File: tb/tb_lfsr_ranged_rng.sv
// Scoreboard bench for lfsr_ranged_rng: draws push predictions, a monitor pops on o_valid.
module tb_lfsr_ranged_rng;

   localparam logic [15:0] TAPS = 16'hD008;
   localparam logic [15:0] SEED = 16'h1314;
   localparam int          MAX_TRIES = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [15:0] seed;
   logic        req;
   logic [15:0] range_v;
   logic        ready;
   logic        valid;
   logic [15:0] value;
   logic [15:0] raw;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          valid_cnt = 0;
   logic [15:0] mdl;

   logic [15:0] exp_val[$];
   int          exp_lat[$];
   int          exp_cyc[$];

   bit          b2b_on = 1'b0;
   logic [9:0]  seen = 10'd0;
   int          max_lat = 0;
   logic [15:0] mon_v;
   int          mon_l;
   int          mon_rc;

   lfsr_ranged_rng dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_seed_load (seed_load),
      .i_seed      (seed),
      .i_req       (req),
      .i_range     (range_v),
      .o_ready     (ready),
      .o_valid     (valid),
      .o_value     (value),
      .o_raw       (raw)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR tracking the expected raw state
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl <= SEED;
      end else if (seed_load) begin
         mdl <= ((seed ^ SEED) == 16'hFFFF) ? SEED : (seed ^ SEED);
      end else begin
         mdl <= {mdl[14:0], ~^(mdl & TAPS)};
      end
   end

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], ~^(s & TAPS)};
   endfunction

   function automatic logic [15:0] mask_of(input logic [15:0] r);
      logic [16:0] m;
      if (r == 16'd0) return 16'hFFFF;
      m = 17'd0;
      while (m < {1'b0, r - 16'd1}) m = {m[15:0], 1'b1};
      return m[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Predict value and latency from the states the draw will see
   task automatic push_draw(input logic [15:0] r);
      logic [15:0] s, m, c, v;
      int lat;
      s = mdl; m = mask_of(r); v = 16'd0; lat = 0;
      for (int k = 1; k <= MAX_TRIES; k++) begin
         s = step(s);
         c = s & m;
         if (lat == 0) begin
            if (r == 16'd0 || c < r) begin
               v = c; lat = k + 1;
            end else if (k == MAX_TRIES) begin
               v = c - r; lat = k + 1;
            end
         end
      end
      exp_val.push_back(v);
      exp_lat.push_back(lat);
      exp_cyc.push_back(cyc);
   endtask

   task automatic issue(input logic [15:0] r);
      chk("ready_before_req", {31'd0, ready}, 32'd1);
      req = 1'b1; range_v = r;
      push_draw(r);
      tick();
      req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_val.size() != 0 || !ready) && n < 40) begin
         tick();
         n++;
      end
      chk("draw_done", {31'd0, (exp_val.size() == 0 && ready)}, 32'd1);
   endtask

   task automatic check_warmup(input logic [15:0] raw1);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 1) chk("raw_after_load", {16'd0, raw}, {16'd0, raw1});
         chk("warmup_ready", {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic wait_reject();
      int n;
      n = 0;
      while (step(mdl) < 16'h8001 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Monitor: raw state every cycle, pops the scoreboard on each o_valid
   initial begin
      forever begin
         @(negedge clk);
         chk("raw", {16'd0, raw}, {16'd0, mdl});
         if (valid) begin
            valid_cnt++;
            if (exp_val.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid actual=%0h required=none", value);
            end else begin
               mon_v  = exp_val.pop_front();
               mon_l  = exp_lat.pop_front();
               mon_rc = exp_cyc.pop_front();
               chk("draw_value", {16'd0, value}, {16'd0, mon_v});
               chk("draw_latency", cyc - mon_rc, mon_l);
               if (b2b_on) begin
                  chk("b2b_below_10", {31'd0, (value < 16'd10)}, 32'd1);
                  if (value < 16'd10) seen[value[3:0]] = 1'b1;
                  if (cyc - mon_rc > max_lat) max_lat = cyc - mon_rc;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, guard, vc;
      rst_n = 1'b0; seed_load = 1'b0; seed = 16'd0; req = 1'b0; range_v = 16'd0;
      tick(); tick();
      chk("rst_raw", {16'd0, raw}, 32'h1314);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_value", {16'd0, value}, 32'd0);
      rst_n = 1'b1;
      check_warmup(16'h2628);

      seed_load = 1'b1; seed = 16'h1314;
      tick();
      seed_load = 1'b0;
      chk("reseed_zero", {16'd0, raw}, 32'h0000);
      chk("reseed_ready", {31'd0, ready}, 32'd0);
      check_warmup(16'h0001);

      seed_load = 1'b1; seed = 16'hECEB;
      tick();
      seed_load = 1'b0;
      chk("lockup_subst", {16'd0, raw}, 32'h1314);
      check_warmup(16'h2628);

      issue(16'd1);     wait_idle();
      issue(16'd0);     wait_idle();
      issue(16'd3);     wait_idle();
      issue(16'h8001);  wait_idle();
      issue(16'hFFFF);  wait_idle();

      b2b_on = 1'b1;
      n = 0; guard = 0;
      while (n < 2000 && guard < 40000) begin
         if (ready) begin
            req = 1'b1; range_v = 16'd10;
            push_draw(16'd10);
            n++;
         end else begin
            req = 1'b0;
         end
         tick();
         guard++;
      end
      req = 1'b0;
      wait_idle();
      b2b_on = 1'b0;
      chk("b2b_count", n, 32'd2000);
      chk("b2b_all_values", {22'd0, seen}, 32'h3FF);
      chk("b2b_max_latency_le9", {31'd0, (max_lat <= 9)}, 32'd1);

      wait_reject();
      vc = valid_cnt;
      req = 1'b1; range_v = 16'h8001;
      tick();
      req = 1'b0;
      chk("draw_ready_low", {31'd0, ready}, 32'd0);
      tick();
      seed_load = 1'b1; seed = 16'h0000;
      tick();
      seed_load = 1'b0;
      chk("abort_raw", {16'd0, raw}, 32'h1314);
      check_warmup(16'h2628);
      chk("abort_no_valid", valid_cnt - vc, 32'd0);

      wait_reject();
      vc = valid_cnt;
      req = 1'b1; range_v = 16'h8001;
      tick();
      req = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_value", {16'd0, value}, 32'd0);
      chk("midrst_raw", {16'd0, raw}, 32'h1314);
      chk("midrst_ready", {31'd0, ready}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      check_warmup(16'h2628);
      chk("midrst_no_valid", valid_cnt - vc, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
